// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC, one-cycle memory tag, stall hold buffer, IF/ID register
//
// Optional feature macro: IF_FETCH_PERF_EN (adds perf_fetch_cnt / perf_bubble_cnt)
//
// Ports:
//   clk             sole clock, rising edge
//   rst             asynchronous active-low reset
//   pc_stall        hold the PC (load-use stall)
//   IF_ID_sf[1:0]   bit1 = hold IF/ID, bit0 = flush IF/ID to a bubble (flush wins)
//   branch_ctrl     nonzero = taken redirect to redirect_pc
//   redirect_pc     redirect target
//   im_oe, im_addr  instruction memory read enable / word address
//   im_dout         instruction memory data, one cycle after the address
//   IF_ID_pc/inst/valid  IF/ID pipeline register
//   perf_fetch_cnt  valid IF/ID loads            (IF_FETCH_PERF_EN only)
//   perf_bubble_cnt invalid IF/ID loads + flushes (IF_FETCH_PERF_EN only)

module if_fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_stall,
    input  logic [1:0]  IF_ID_sf,
    input  logic [1:0]  branch_ctrl,
    input  logic [31:0] redirect_pc,
    output logic        im_oe,
    output logic [13:0] im_addr,
    input  logic [31:0] im_dout,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_valid
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        redirect;
    logic [31:0] pc;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    logic        hold_valid;
    logic [31:0] src_pc;
    logic [31:0] src_inst;
    logic        src_valid;
    logic        ifid_flush;
    logic        ifid_load;

    assign redirect   = |branch_ctrl;
    assign ifid_flush = IF_ID_sf[0];
    assign ifid_load  = ~IF_ID_sf[0] & ~IF_ID_sf[1];

    assign im_addr = pc[15:2];
    assign im_oe   = rst & (~pc_stall | redirect);

    // Redirect beats stall; the +4 wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= 32'h0;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (!pc_stall) begin
            pc <= pc + 32'd4;
        end
    end

    // Tag for the word that im_dout returns next cycle. A redirect kills the
    // word launched this cycle because it belongs to the wrong path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= 32'h0;
            fetch_valid <= 1'b0;
        end else begin
            fetch_pc    <= pc;
            fetch_valid <= im_oe & ~redirect;
        end
    end

    // The memory only presents its data for one cycle, so a word arriving
    // while IF/ID is held must be parked here or it would be lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_pc    <= 32'h0;
            hold_inst  <= 32'h0;
            hold_valid <= 1'b0;
        end else if (ifid_flush || ifid_load) begin
            hold_valid <= 1'b0;
        end else if (fetch_valid && !hold_valid) begin
            hold_pc    <= fetch_pc;
            hold_inst  <= im_dout;
            hold_valid <= 1'b1;
        end
    end

    always_comb begin
        src_pc    = fetch_pc;
        src_inst  = im_dout;
        src_valid = fetch_valid;
        if (hold_valid) begin
            src_pc    = hold_pc;
            src_inst  = hold_inst;
            src_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            IF_ID_pc    <= 32'h0;
            IF_ID_inst  <= NOP;
            IF_ID_valid <= 1'b0;
        end else if (ifid_flush) begin
            IF_ID_pc    <= 32'h0;
            IF_ID_inst  <= NOP;
            IF_ID_valid <= 1'b0;
        end else if (ifid_load) begin
            IF_ID_pc    <= src_pc;
            IF_ID_inst  <= src_valid ? src_inst : NOP;
            IF_ID_valid <= src_valid;
        end
    end

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt  <= 32'h0;
            perf_bubble_cnt <= 32'h0;
        end else begin
            if (ifid_load && src_valid) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (ifid_flush || (ifid_load && !src_valid)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage

module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        pc_stall;
    logic [1:0]  IF_ID_sf;
    logic [1:0]  branch_ctrl;
    logic [31:0] redirect_pc;
    logic        im_oe;
    logic [13:0] im_addr;
    logic [31:0] im_dout;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        IF_ID_valid;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    if_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_stall    (pc_stall),
        .IF_ID_sf    (IF_ID_sf),
        .branch_ctrl (branch_ctrl),
        .redirect_pc (redirect_pc),
        .im_oe       (im_oe),
        .im_addr     (im_addr),
        .im_dout     (im_dout),
        .IF_ID_pc    (IF_ID_pc),
        .IF_ID_inst  (IF_ID_inst),
        .IF_ID_valid (IF_ID_valid)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns the byte address of the word (low 16 bits).
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {16'h0, a[15:2], 2'b00};
    endfunction

    always @(posedge clk) begin
        if (im_oe) im_dout <= {16'h0, im_addr, 2'b00};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference state: architectural PC, next correct-path address the
    // decoder must see, and what IF/ID is expected to hold.
    logic [31:0] m_pc;
    logic [31:0] m_next;
    logic        m_valid;
    logic [31:0] m_ifid_pc;
    logic [31:0] m_ifid_inst;
    int          idle;
    int          m_fetch_cnt;
    int          m_bubble_cnt;

    task automatic model_reset();
        m_pc = 0; m_next = 0; m_valid = 0; m_ifid_pc = 0; m_ifid_inst = NOP;
        idle = 0; m_fetch_cnt = 0; m_bubble_cnt = 0;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic ps, input logic [1:0] sf, input logic [1:0] br,
                        input logic [31:0] rpc);
        logic [31:0] nxt;
        pc_stall = ps; IF_ID_sf = sf; branch_ctrl = br; redirect_pc = rpc;
        #1;
        check("im_addr", {18'h0, im_addr}, {18'h0, m_pc[15:2]});
        check("im_oe", {31'h0, im_oe}, {31'h0, (!ps || br != 2'b00)});
        if (br != 2'b00) nxt = rpc;
        else if (ps)     nxt = m_pc;
        else             nxt = m_pc + 32'd4;
        @(posedge clk);
        @(negedge clk);
        m_pc = nxt;
        idle++;
        if (sf[0]) begin
            check("flush_valid", {31'h0, IF_ID_valid}, 32'h0);
            check("flush_inst", IF_ID_inst, NOP);
            check("flush_pc", IF_ID_pc, 32'h0);
            m_valid = 0; m_ifid_inst = NOP; m_ifid_pc = 0;
            m_bubble_cnt++;
        end else if (sf[1]) begin
            check("hold_valid_out", {31'h0, IF_ID_valid}, {31'h0, m_valid});
            check("hold_inst_out", IF_ID_inst, m_ifid_inst);
            if (m_valid) check("hold_pc_out", IF_ID_pc, m_ifid_pc);
        end else if (IF_ID_valid) begin
            check("seq_pc", IF_ID_pc, m_next);
            check("seq_inst", IF_ID_inst, word_of(m_next));
            m_valid = 1; m_ifid_pc = m_next; m_ifid_inst = word_of(m_next);
            m_next = m_next + 32'd4;
            m_fetch_cnt++;
            idle = 0;
        end else begin
            check("bubble_inst", IF_ID_inst, NOP);
            m_valid = 0; m_ifid_inst = NOP;
            m_bubble_cnt++;
        end
        if (br != 2'b00) m_next = rpc;
        if (idle > 64) begin
            check("progress", 32'(idle), 32'd0);
            idle = 0;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_valid", {31'h0, IF_ID_valid}, 32'h0);
        check("rst_inst", IF_ID_inst, NOP);
        check("rst_pc", IF_ID_pc, 32'h0);
        check("rst_im_oe", {31'h0, im_oe}, 32'h0);
        check("rst_im_addr", {18'h0, im_addr}, 32'h0);
        check("rst_hold", {31'h0, dut.hold_valid}, 32'h0);
        check("rst_fetch", {31'h0, dut.fetch_valid}, 32'h0);
        pc_stall = 0; IF_ID_sf = 0; branch_ctrl = 0; redirect_pc = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int r;
        logic ps;
        logic [1:0] sf, br;
        logic [31:0] rpc;
        rst = 1'b1; pc_stall = 0; IF_ID_sf = 0; branch_ctrl = 0; redirect_pc = 0;
        model_reset();
        reset_dut();

        // Reset release, straight-line fetch.
        step(0, 2'b00, 2'b00, 0);
        check("e1_valid", {31'h0, IF_ID_valid}, 32'h0);
        step(0, 2'b00, 2'b00, 0);
        check("e2_valid", {31'h0, IF_ID_valid}, 32'h1);
        check("e2_pc", IF_ID_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 2'b00, 2'b00, 0);
            check("run_valid", {31'h0, IF_ID_valid}, 32'h1);
        end
        check("run_pc_0c", IF_ID_pc, 32'h0C);

        // One-cycle stall while word 0x10 is in flight.
        step(1, 2'b10, 2'b00, 0);
        check("stall_hold_set", {31'h0, dut.hold_valid}, 32'h1);
        check("stall_pc_0c", IF_ID_pc, 32'h0C);
        step(0, 2'b00, 2'b00, 0);
        check("after_stall_10", IF_ID_pc, 32'h10);
        step(0, 2'b00, 2'b00, 0);
        check("after_stall_14", IF_ID_pc, 32'h14);

        // Redirect with flush at pc 0x20.
        for (int i = 0; i < 8 && m_pc != 32'h20; i++) step(0, 2'b00, 2'b00, 0);
        check("at_pc_20", m_pc, 32'h20);
        step(0, 2'b01, 2'b01, 32'h100);
        step(0, 2'b00, 2'b00, 0);
        check("redir_bubble2", {31'h0, IF_ID_valid}, 32'h0);
        step(0, 2'b00, 2'b00, 0);
        check("redir_target", IF_ID_pc, 32'h100);

        // Redirect wins over pc_stall, then stall in the first cycle after it.
        step(1, 2'b01, 2'b10, 32'h200);
        check("redir_stall_addr", {18'h0, im_addr}, 32'h80);
        step(1, 2'b10, 2'b00, 0);
        step(1, 2'b10, 2'b00, 0);
        for (int i = 0; i < 3; i++) step(0, 2'b00, 2'b00, 0);

        // PC wrap.
        step(0, 2'b01, 2'b01, 32'hFFFF_FFFC);
        step(0, 2'b00, 2'b00, 0);
        check("wrap_addr", {18'h0, im_addr}, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 2'b00, 2'b00, 0);

        // Reset in the third cycle of a stall with the hold buffer full.
        step(1, 2'b10, 2'b00, 0);
        check("pre_rst_hold", {31'h0, dut.hold_valid}, 32'h1);
        step(1, 2'b10, 2'b00, 0);
        pc_stall = 1; IF_ID_sf = 2'b10;
        reset_dut();
        step(0, 2'b00, 2'b00, 0);
        check("rst2_e1_valid", {31'h0, IF_ID_valid}, 32'h0);
        step(0, 2'b00, 2'b00, 0);
        check("rst2_e2_pc", IF_ID_pc, 32'h0);
        check("rst2_e2_valid", {31'h0, IF_ID_valid}, 32'h1);

        // Random traffic honouring the hazard unit's contract: an IF/ID hold
        // always comes with a PC hold, and every redirect flushes IF/ID.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            ps = 0; sf = 2'b00; br = 2'b00; rpc = 0;
            if (r < 8) begin
                br  = 2'($urandom_range(1, 3));
                ps  = 1'($urandom_range(0, 1));
                sf  = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01;
                rpc = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            end else if (r < 30) begin
                ps = 1; sf = 2'b10;
            end else if (r < 38) begin
                ps = 1;
            end
            step(ps, sf, br, rpc);
        end

`ifdef IF_FETCH_PERF_EN
        check("perf_fetch", perf_fetch_cnt, 32'(m_fetch_cnt));
        check("perf_bubble", perf_bubble_cnt, 32'(m_bubble_cnt));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL provide ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL provide: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: pc_stall  in  1  hold PC (load-use stall from hazard control).
REQ-004 SHALL provide: IF_ID_sf  in  2  IF/ID control; bit1 = stall (hold), bit0 = flush (bubble).
REQ-005 SHALL provide: branch_ctrl  in  2  redirect request; any nonzero value = taken redirect.
REQ-006 SHALL provide: redirect_pc  in  32  redirect target, sampled when branch_ctrl != 0.
REQ-007 SHALL provide: im_oe  out  1  instruction memory read enable.
REQ-008 SHALL provide: im_addr  out  14  instruction memory word address.
REQ-009 SHALL provide: im_dout  in  32  instruction memory data, valid one cycle after the address.
REQ-010 SHALL provide: IF_ID_pc  out  32, IF_ID_inst  out  32, IF_ID_valid  out  1  IF/ID pipeline register.

Function
REQ-011 pc register SHALL update per edge: branch_ctrl != 0 -> redirect_pc; else pc_stall -> hold; else pc + 4; the sum is modulo 2^32.
REQ-012 im_addr SHALL equal pc[15:2] combinationally.
REQ-013 im_oe SHALL equal (!pc_stall || branch_ctrl != 0); rst low forces it to 0.
REQ-014 fetch_pc/fetch_valid SHALL record the pc and im_oe presented each cycle, so that im_dout is tagged one cycle later.
REQ-015 On a redirect, fetch_valid SHALL clear on the next edge, discarding the in-flight wrong-path word; fetch of the target resumes with data 2 cycles after branch_ctrl.
REQ-016 Priority SHALL be: redirect > stall; a redirect with pc_stall high still loads redirect_pc.
REQ-017 hold buffer: when IF_ID_sf[1] = 1 and fetch_valid = 1 and hold_valid = 0, the block SHALL capture im_dout/fetch_pc into hold_inst/hold_pc and set hold_valid.
REQ-018 Source word SHALL be the hold buffer when hold_valid = 1, else im_dout/fetch_pc with validity fetch_valid.
REQ-019 IF/ID update priority SHALL be: flush (bit0) -> IF_ID_valid = 0, IF_ID_inst = 32'h0000_0013, IF_ID_pc = 0; else stall (bit1) -> hold all; else load the source word, with IF_ID_valid = source validity and IF_ID_inst = NOP when invalid.
REQ-020 hold_valid SHALL clear on any IF/ID load or flush; a flush also discards the hold contents.
REQ-021 The block SHALL never drop or duplicate a correct-path instruction across a stall of any length, including a stall arriving in the first fetch cycle after a redirect.
REQ-022 A simultaneous IF_ID_sf = 2'b11 SHALL be treated as a flush.

Reset
REQ-023 While rst = 0 the block SHALL hold: pc = 0, fetch_valid = 0, hold_valid = 0, IF_ID_valid = 0, IF_ID_inst = 32'h0000_0013, IF_ID_pc = 0, im_oe = 0.
REQ-024 After rst is released, the first edge SHALL launch the fetch of address 0; IF_ID_valid first rises on the 2nd edge.
REQ-025 rst asserted mid-stall or mid-redirect SHALL discard all in-flight and held state immediately.

Configuration
REQ-026 With macro IF_FETCH_PERF_EN defined, the block SHALL add outputs perf_fetch_cnt (32) and perf_bubble_cnt (32), counting IF/ID loads with valid = 1 and IF/ID loads or flushes with valid = 0; both reset to 0 and wrap.
REQ-027 Without IF_FETCH_PERF_EN, those ports and counters SHALL be absent and all other behaviour identical.

Verification
REQ-028 Reset release, no stalls, memory returns word = address -> IF_ID_pc 0,4,8,... on successive cycles, with IF_ID_valid high from the 2nd edge.
REQ-029 pc_stall + IF_ID_sf = 2'b10 for 1 cycle while fetching 0x10 -> im_oe = 0 that cycle, hold_valid set, IF_ID shows 0x0C twice then 0x10, with no gap or duplicate of 0x10.
REQ-030 branch_ctrl = 01, redirect_pc = 0x100, IF_ID_sf = 01 at pc 0x20 -> IF_ID bubble (NOP, valid 0) for 2 cycles, then IF_ID_pc = 0x100.
REQ-031 branch_ctrl = 10 together with pc_stall = 1 -> pc loads the redirect target; stall ignored.
REQ-032 rst low during a 3-cycle stall with hold_valid = 1 -> all outputs return to REQ-023 values asynchronously, and fetch restarts at 0.
REQ-033 pc = 0xFFFF_FFFC, no stall -> next pc = 0x0000_0000; with IF_FETCH_PERF_EN, perf counters match the counted valid loads and bubbles.
